// File: rtl/pc_fetch_unit_pkg.sv
// pc_fetch_unit_pkg: shared defaults, next-state selector and redirect target helpers
package pc_fetch_unit_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int MEM_DEPTH_DEF = 128;
  localparam int RESET_PC_DEF = 0;
  typedef enum logic [1:0] {NX_SEQ, NX_STALL, NX_REDIRECT, NX_FAULT} next_sel_e;
  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction
  function automatic logic [31:0] jump_target(input logic [31:0] pc_plus1, input logic [25:0] index26);
    return {pc_plus1[31:26], index26};
  endfunction
endpackage

// File: rtl/pc_fetch_unit_if_id_reg.sv
// if_id_reg: IF/ID pipeline register with load enable and synchronous clear
module if_id_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        clr,
  input  logic [31:0] d_inst,
  input  logic [31:0] d_pc_plus1,
  output logic [31:0] q_inst,
  output logic [31:0] q_pc_plus1,
  output logic        q_valid
);
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q_inst <= '0;
      q_pc_plus1 <= '0;
      q_valid <= 1'b0;
    end else if (en) begin
      q_inst <= d_inst;
      q_pc_plus1 <= d_pc_plus1;
      q_valid <= 1'b1;
    end
  end
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: word-indexed PC, next-PC mux and IF/ID capture with sticky range fault
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int MEM_DEPTH = MEM_DEPTH_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic              PCclk,
  input  logic              PCrst,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_pc_plus1,
  input  logic [15:0]       branch_imm16,
  input  logic              jump_en,
  input  logic [25:0]       jump_index26,
  input  logic [31:0]       inst,
  output logic [ADDR_W-1:0] inst_addr,
  output logic [31:0]       if_id_inst,
  output logic [ADDR_W-1:0] if_id_pc_plus1,
  output logic              if_id_valid,
  output logic              fetch_fault,
  output logic [31:0]       fetch_count
);
  logic [ADDR_W-1:0] pc, pc_plus1, target;
  next_sel_e sel;
  assign inst_addr = pc;
  assign pc_plus1 = pc + 1'b1;
  // jump wins over branch when both are (illegally) raised together
  assign target = jump_en ? jump_target(branch_pc_plus1, jump_index26)
                          : branch_pc_plus1 + sext16(branch_imm16);
  assign sel = (fetch_fault || pc >= ADDR_W'(MEM_DEPTH)) ? NX_FAULT
             : (jump_en || branch_taken) ? NX_REDIRECT
             : stall ? NX_STALL : NX_SEQ;
  always_ff @(posedge PCclk) begin
    if (PCrst) begin
      pc <= RESET_PC;
      fetch_fault <= 1'b0;
      fetch_count <= '0;
    end else begin
      pc <= sel == NX_REDIRECT ? target : sel == NX_SEQ ? pc_plus1 : pc;
      fetch_fault <= fetch_fault | (sel == NX_FAULT);
      fetch_count <= fetch_count + 32'(sel == NX_SEQ);
    end
  end
  if_id_reg u_if_id (
    .clk(PCclk),
    .rst(PCrst),
    .en(sel == NX_SEQ),
    .clr(sel == NX_REDIRECT || sel == NX_FAULT),
    .d_inst(inst),
    .d_pc_plus1(pc_plus1),
    .q_inst(if_id_inst),
    .q_pc_plus1(if_id_pc_plus1),
    .q_valid(if_id_valid)
  );
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: scoreboard bench driving directed and random fetch/redirect/stall traffic
module tb_pc_fetch_unit;
  logic        PCclk = 1'b0;
  logic        PCrst, stall, branch_taken, jump_en;
  logic [31:0] branch_pc_plus1, inst, inst_addr, if_id_inst, if_id_pc_plus1, fetch_count;
  logic [15:0] branch_imm16;
  logic [25:0] jump_index26;
  logic        if_id_valid, fetch_fault;
  logic [31:0] mem [128];
  int total = 0, bad = 0;
  typedef struct {
    logic [31:0] pc, ii, ip, cnt;
    logic v, f;
  } st_t;
  st_t m;
  st_t sb[$];
  always #5 PCclk = ~PCclk;
  assign inst = inst_addr < 32'd128 ? mem[inst_addr[6:0]] : 32'h0;
  pc_fetch_unit dut (
    .PCclk(PCclk), .PCrst(PCrst), .stall(stall), .branch_taken(branch_taken),
    .branch_pc_plus1(branch_pc_plus1), .branch_imm16(branch_imm16), .jump_en(jump_en),
    .jump_index26(jump_index26), .inst(inst), .inst_addr(inst_addr), .if_id_inst(if_id_inst),
    .if_id_pc_plus1(if_id_pc_plus1), .if_id_valid(if_id_valid), .fetch_fault(fetch_fault),
    .fetch_count(fetch_count)
  );
  always @(posedge PCclk)
    assert (!(jump_en && branch_taken)) else $error("illegal: jump_en and branch_taken together");
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step(input logic r, input logic s, input logic bt, input logic [31:0] bp1,
                      input logic [15:0] imm, input logic je, input logic [25:0] ji);
    st_t e, n;
    PCrst = r; stall = s; branch_taken = bt; branch_pc_plus1 = bp1;
    branch_imm16 = imm; jump_en = je; jump_index26 = ji;
    n = m;
    if (r) n = '{pc: 0, ii: 0, ip: 0, cnt: 0, v: 0, f: 0};
    else if (m.f || m.pc >= 128) begin
      n.f = 1; n.v = 0; n.ii = 0; n.ip = 0;
    end else if (je || bt) begin
      n.pc = je ? {bp1[31:26], ji} : bp1 + {{16{imm[15]}}, imm};
      n.v = 0; n.ii = 0; n.ip = 0;
    end else if (!s) begin
      n.ii = mem[m.pc[6:0]]; n.ip = m.pc + 1; n.v = 1; n.pc = m.pc + 1; n.cnt = m.cnt + 1;
    end
    m = n;
    sb.push_back(n);
    @(posedge PCclk);
    #1;
    if (sb.size() == 0) chk("sb_empty", 0, 1);
    else begin
      e = sb.pop_front();
      chk("pc", inst_addr, e.pc);
      chk("ii", if_id_inst, e.ii);
      chk("ip", if_id_pc_plus1, e.ip);
      chk("valid", {31'b0, if_id_valid}, {31'b0, e.v});
      chk("fault", {31'b0, fetch_fault}, {31'b0, e.f});
      chk("count", fetch_count, e.cnt);
    end
  endtask
  task automatic seq(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'hC0DE_0000 + 32'(i * 7);
    mem[0] = 32'hAAAA_AAAA; mem[1] = 32'hBBBB_BBBB; mem[2] = 32'hCCCC_CCCC; mem[3] = 32'hDDDD_DDDD;
    m = '{pc: 32'hFFFF_FFFF, ii: 0, ip: 0, cnt: 0, v: 0, f: 0};
    step(1, 0, 0, 0, 0, 0, 0);
    chk("rst_pc", inst_addr, 0);
    chk("rst_valid", {31'b0, if_id_valid}, 0);
    seq(1);
    chk("first_inst", if_id_inst, 32'hAAAA_AAAA);
    chk("first_pc1", if_id_pc_plus1, 1);
    seq(3);
    chk("cnt4", fetch_count, 4);
    chk("addr4", inst_addr, 4);
    chk("d_inst", if_id_inst, 32'hDDDD_DDDD);
    step(1, 0, 0, 0, 0, 0, 0);
    seq(2);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0, 0);
    chk("stall_addr", inst_addr, 2);
    chk("stall_inst", if_id_inst, 32'hBBBB_BBBB);
    chk("stall_cnt", fetch_count, 2);
    seq(1);
    chk("resume_inst", if_id_inst, 32'hCCCC_CCCC);
    step(0, 0, 1, 5, 16'hFFFD, 0, 0);
    chk("br_back", inst_addr, 2);
    chk("br_flush", {31'b0, if_id_valid}, 0);
    seq(1);
    chk("br_valid", {31'b0, if_id_valid}, 1);
    step(0, 0, 1, 5, 16'h0010, 0, 0);
    chk("br_fwd", inst_addr, 32'h15);
    step(0, 1, 0, 7, 0, 1, 26'h40);
    chk("jmp_stall", inst_addr, 32'h40);
    chk("jmp_flush", {31'b0, if_id_valid}, 0);
    step(0, 0, 0, 0, 0, 1, 26'd127);
    seq(1);
    chk("pc128", inst_addr, 128);
    seq(1);
    chk("fault", {31'b0, fetch_fault}, 1);
    chk("fault_hold", inst_addr, 128);
    step(0, 0, 1, 0, 16'h0004, 0, 0);
    step(0, 0, 0, 0, 0, 1, 26'd3);
    chk("fault_ign", inst_addr, 128);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("fault_clr", {31'b0, fetch_fault}, 0);
    seq(9);
    chk("pc9", inst_addr, 9);
    step(1, 1, 0, 0, 0, 0, 0);
    chk("rst_stall_pc", inst_addr, 0);
    chk("rst_stall_cnt", fetch_count, 0);
    for (int i = 0; i < 120; i++) begin
      int k = $urandom_range(0, 19);
      step(k == 0, k inside {[1:4]}, k inside {[5:6]}, $urandom_range(0, 140), 16'($urandom_range(0, 65535)),
           k == 7, 26'($urandom_range(0, 135)));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
